// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the ALU request scheduler.
package alu_sched_pkg;

   localparam int OPW = 2;
   localparam int DW  = 8;

   localparam logic BANK_A = 1'b0;
   localparam logic BANK_B = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational first-set search starting at the
// pointer, pointer advances past the winner when a grant is accepted.
module rr_arbiter #(
   parameter  int NREQ = 2,
   localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic            alu_clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   input  logic            accept,
   output logic [NREQ-1:0] gnt,
   output logic [IW-1:0]   gnt_idx,
   output logic            any_req
);

   logic [IW-1:0] ptr_q;

   // Scan from the pointer and pick the first requester that is valid.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      any_req = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (!any_req && req[(int'(ptr_q) + i) % NREQ]) begin
            any_req = 1'b1;
            gnt_idx = IW'((int'(ptr_q) + i) % NREQ);
         end
      end
      if (any_req) begin
         gnt = NREQ'(1) << gnt_idx;
      end
   end

   // Pointer moves to the requester after the winner, wrapping at NREQ.
   always_ff @(posedge alu_clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else if (accept) begin
         ptr_q <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
      end
   end

endmodule

// File: rtl/alu_req_sched.sv
// Shares one ALU between NREQ requesters: round-robin accept, one issue
// cycle, wait the result latency, return the result, then clear the irq.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. req_ready is only ever raised in IDLE, for the arbiter winner, and
// does not depend on anything but req_valid and the pointer. resp_valid is
// held with stable resp_data/resp_irq until the owner's resp_ready is seen.
module alu_req_sched
   import alu_sched_pkg::*;
#(
   parameter int NREQ       = 2,
   parameter int RESULT_LAT = 1
) (
   input  logic              alu_clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ-1:0]   req_bank,
   input  logic [2*NREQ-1:0] req_op,
   input  logic [8*NREQ-1:0] req_a,
   input  logic [8*NREQ-1:0] req_b,
   output logic [NREQ-1:0]   resp_valid,
   input  logic [NREQ-1:0]   resp_ready,
   output logic [DW-1:0]     resp_data,
   output logic              resp_irq,
   output logic              busy,
   output logic              alu_enable,
   output logic              alu_enable_a,
   output logic              alu_enable_b,
   output logic [OPW-1:0]    alu_op_a,
   output logic [OPW-1:0]    alu_op_b,
   output logic [DW-1:0]     alu_in_a,
   output logic [DW-1:0]     alu_in_b,
   output logic              alu_irq_clr,
   input  logic [DW-1:0]     alu_out,
   input  logic              alu_irq,
   output sched_state_e      dbg_state
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = (RESULT_LAT > 1) ? $clog2(RESULT_LAT) : 1;

   sched_state_e    state_q, state_d;
   logic [IW-1:0]   owner_q;
   logic [CW-1:0]   cnt_q;
   logic [NREQ-1:0] gnt;
   logic [IW-1:0]   gnt_idx;
   logic            any_req;
   logic            accept;
   logic            resp_done;
   logic            sel_bank;
   logic [OPW-1:0]  sel_op;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .alu_clk (alu_clk),
      .rst     (rst),
      .req     (req_valid),
      .accept  (accept),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .any_req (any_req)
   );

   assign sel_bank = req_bank[gnt_idx];
   assign sel_op   = req_op[OPW*gnt_idx +: OPW];

   // State register.
   always_ff @(posedge alu_clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic and the accept / response-complete strobes.
   always_comb begin
      state_d   = state_q;
      accept    = 1'b0;
      resp_done = 1'b0;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               accept  = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: state_d = WAIT;
         WAIT: begin
            if (cnt_q == '0) begin
               state_d = RESP;
            end
         end
         RESP: begin
            if (resp_ready[owner_q]) begin
               resp_done = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Registered ALU drive, wait counter, owner and result capture.
   always_ff @(posedge alu_clk) begin
      if (rst) begin
         owner_q      <= '0;
         cnt_q        <= '0;
         alu_enable   <= 1'b0;
         alu_enable_a <= 1'b0;
         alu_enable_b <= 1'b0;
         alu_op_a     <= '0;
         alu_op_b     <= '0;
         alu_in_a     <= '0;
         alu_in_b     <= '0;
         alu_irq_clr  <= 1'b1;
         resp_data    <= '0;
         resp_irq     <= 1'b0;
      end else begin
         alu_irq_clr <= resp_done;
         if (accept) begin
            owner_q      <= gnt_idx;
            alu_enable   <= 1'b1;
            alu_enable_a <= (sel_bank == BANK_A);
            alu_enable_b <= (sel_bank == BANK_B);
            alu_op_a     <= (sel_bank == BANK_A) ? sel_op : '0;
            alu_op_b     <= (sel_bank == BANK_B) ? sel_op : '0;
            alu_in_a     <= req_a[DW*gnt_idx +: DW];
            alu_in_b     <= req_b[DW*gnt_idx +: DW];
         end
         if (state_q == ISSUE) begin
            alu_enable   <= 1'b0;
            alu_enable_a <= 1'b0;
            alu_enable_b <= 1'b0;
            cnt_q        <= CW'(RESULT_LAT - 1);
         end
         if (state_q == WAIT) begin
            if (cnt_q == '0) begin
               resp_data <= alu_out;
               resp_irq  <= alu_irq;
            end else begin
               cnt_q <= cnt_q - CW'(1);
            end
         end
      end
   end

   assign req_ready  = (state_q == IDLE && !rst) ? gnt : '0;
   assign resp_valid = (state_q == RESP) ? (NREQ'(1) << owner_q) : '0;
   assign busy       = (state_q != IDLE);
   assign dbg_state  = state_q;

endmodule

// File: doc/alu_req_sched.md
Name: alu_req_sched

Overview:
- Shares one ALU datapath between NREQ independent requesters using a valid/ready command interface and a valid/ready response interface.
- Performs round-robin arbitration among requesters.
- Drives the ALU enable, bank-select, opcode and operand inputs for exactly one issue cycle per command.
- Waits the ALU result latency, captures alu_out/alu_irq, returns them to the winning requester, then clears the ALU interrupt.
- Sits between the command sources and the ALU; it is the only master of the ALU inputs.

Parameters:
- NREQ, 2, number of requesters (2..4).
- RESULT_LAT, 1, cycles from the ALU issue edge until alu_out is valid to sample.

Ports:
- alu_clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester command valid.
- req_ready  out  NREQ  per-requester command accept; one-hot or zero.
- req_bank  in  NREQ  per-requester bank: 0 selects op set A, 1 selects op set B.
- req_op  in  2*NREQ  per-requester opcode; slice [2i+1:2i].
- req_a  in  8*NREQ  per-requester operand A; slice [8i+7:8i].
- req_b  in  8*NREQ  per-requester operand B; same slicing.
- resp_valid  out  NREQ  one-hot response valid to the owning requester.
- resp_ready  in  NREQ  per-requester response accept.
- resp_data  out  8  captured ALU result; shared by all requesters.
- resp_irq  out  1  captured ALU interrupt; shared.
- busy  out  1  high in any state other than IDLE.
- alu_enable, alu_enable_a, alu_enable_b  out  1 each  ALU control strobes.
- alu_op_a, alu_op_b  out  2 each  ALU opcodes.
- alu_in_a, alu_in_b  out  8 each  ALU operands.
- alu_irq_clr  out  1  ALU interrupt clear.
- alu_out  in  8  ALU result.
- alu_irq  in  1  ALU interrupt.

Behaviour:
- Reset, sampled while rst=1 at an edge:
  - State goes to IDLE; round-robin pointer goes to 0.
  - All outputs become 0, except alu_irq_clr, which becomes 1.
  - Any in-flight command is discarded and no response is produced.
- All ALU-facing outputs are registered.
- FSM states:
  - IDLE: the arbiter scans from the round-robin pointer for the first requester with req_valid=1 and pulses req_ready for that requester only. The accepted requester's bank, op, a and b are latched; the winner index is stored as owner; pointer becomes (owner+1) mod NREQ. Next state is ISSUE. With no valid requester, stay in IDLE.
  - ISSUE, one cycle:
    - alu_enable=1 and alu_irq_clr=0.
    - bank 0: alu_enable_a=1, alu_enable_b=0, alu_op_a=op.
    - bank 1: alu_enable_a=0, alu_enable_b=1, alu_op_b=op.
    - alu_in_a/alu_in_b carry the latched operands.
    - Unused opcode output is driven 0.
    - Next state WAIT; the wait counter is loaded with RESULT_LAT-1.
  - WAIT: alu_enable, alu_enable_a and alu_enable_b are 0 and operands are held. When the counter reaches 0, alu_out and alu_irq are captured into resp_data and resp_irq at that edge and the next state is RESP. Otherwise the counter decrements.
  - RESP:
    - resp_valid[owner]=1; resp_data and resp_irq are stable.
    - On resp_ready[owner]=1: resp_valid drops next cycle and alu_irq_clr pulses 1 for one cycle. Next state is IDLE.
    - Without the handshake, hold indefinitely.
- Command acceptance to resp_valid is 2+RESULT_LAT cycles (3 by default). Minimum command spacing is 3+RESULT_LAT cycles.
- Results the ALU does not update (gated opcodes/operands) are returned as whatever alu_out holds; the scheduler never inspects opcode semantics.
- resp_ready on a non-owner is ignored. req_valid seen outside IDLE is not accepted (req_ready=0).
- A request held valid across a grant to another requester keeps priority per round-robin order; no starvation beyond NREQ-1 commands.
- rst asserted in any state takes effect at that edge; the pulse-width for req_ready/resp_valid ends immediately.

Decomposition:
- Package alu_sched_pkg holds:
  - state enum: IDLE, ISSUE, WAIT, RESP;
  - BANK_A=0 and BANK_B=1 constants;
  - width constants OPW=2 and DW=8.
- Sub-module rr_arbiter(NREQ): combinational first-set-from-pointer grant, plus registered pointer update on accept. It is instantiated once.

Test Plan:
- Single command, requester 0 with bank 0, op 2'b10, a=8'hF0, b=8'h08 -> one ISSUE cycle with alu_enable_a=1; resp_valid[0] 3 cycles after accept; resp_data=8'hF8, resp_irq=1; alu_irq_clr pulses after resp_ready.
- req_valid=2'b11 held for 4 commands -> grants in order 0,1,0,1; resp_valid is one-hot matching each owner.
- Requester 1 with bank 1, op 2'b01, b=8'h03, sent after a command leaving alu_out=8'hF8 -> resp_data=8'hF8 (ALU hold), and the handshake completes normally.
- resp_ready held 0 for 10 cycles in RESP -> resp_valid and resp_data stable, no new req_ready, busy=1. Raising resp_ready returns the FSM to IDLE the next cycle.
- rst=1 asserted during WAIT -> the next cycle shows IDLE, all outputs 0 with alu_irq_clr=1, no response. The next request is granted to requester 0.
- RESULT_LAT=3 build -> response arrives 5 cycles after accept, and alu_out is sampled on the third WAIT cycle.
